elevator_plant_model: RTL and testbench
=======================================

ELEVATOR_PLANT_MODEL -- requirements
Module: elevator_plant_model

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 4, number of floors (2..16).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 2500, clocks to travel one floor (>=2).
REQ-003 SHALL have parameter DWELL_CYCLES, default 50, clocks the floor sensor is held after arrival (>=1).
REQ-004 SHALL have parameter INIT_FLOOR, default 0, floor after reset (< NUM_FLOORS); FLOOR_W = clog2(NUM_FLOORS), min 1.
REQ-005 SHALL have port clock  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port motorSubindo  in  1  motor up command.
REQ-008 SHALL have port motorDescendo  in  1  motor down command.
REQ-009 SHALL have port sensoresNeg  out  NUM_FLOORS  active-low one-hot floor sensors; all ones between floors.
REQ-010 SHALL have port andar  out  FLOOR_W  last floor reached.
REQ-011 SHALL have port em_movimento  out  1  high while in TRANSITO.
REQ-012 SHALL have port chegou  out  1  one-cycle pulse on arrival.
REQ-013 SHALL have port falha  out  1  high the cycle after both motor inputs sampled high.
REQ-014 SHALL have port sobrecurso  out  1  sticky: move commanded past top or bottom floor.

Function
REQ-015 All outputs SHALL be registered; the plant SHALL be an FSM with states PARADO, TRANSITO, CHEGADA.
REQ-016 Effective command: up = motorSubindo & ~motorDescendo; down = motorDescendo & ~motorSubindo; both high SHALL count as no command and set falha next cycle.
REQ-017 PARADO: sensoresNeg bit andar low, others high; legal up/down SHALL latch direction, clear travel counter, enter TRANSITO next cycle with sensoresNeg all ones.
REQ-018 PARADO with up at floor NUM_FLOORS-1 or down at floor 0 SHALL stay in PARADO and set sobrecurso until reset.
REQ-019 TRANSITO: counter SHALL increment each cycle the command equals latched direction, and hold when no command.
REQ-020 TRANSITO with opposite command SHALL flip latched direction and load counter with TRAVEL_CYCLES-1-count, andar unchanged.
REQ-021 When counter equals TRAVEL_CYCLES-1 and command matches direction, next cycle: andar +/-1 (toward target floor), state CHEGADA, target sensor low, chegou=1 for exactly one cycle.
REQ-022 Reversal back to the origin floor SHALL arrive at origin floor with andar unchanged and chegou pulsed.
REQ-023 CHEGADA SHALL hold the sensor for DWELL_CYCLES cycles ignoring motor inputs, then enter PARADO; a command then present SHALL start travel the cycle after PARADO is entered.
REQ-024 Floor arithmetic SHALL never wrap; andar stays within 0..NUM_FLOORS-1.

Reset
REQ-025 reset high SHALL, at the next edge, override all activity, mid-travel included: state PARADO, andar=INIT_FLOOR, counters 0, direction up, sensoresNeg=~(1<<INIT_FLOOR), em_movimento=0, chegou=0, falha=0, sobrecurso=0.

Structure
REQ-026 Shared package elevator_sim_pkg SHALL hold the state typedef (PARADO, TRANSITO, CHEGADA), direction typedef, and one-hot-low sensor encoding function.
REQ-027 Travel counter with increment/hold/mirror-load SHALL be sub-module contador_viagem, parametrised by TRAVEL_CYCLES.

Verification (NUM_FLOORS=4, TRAVEL_CYCLES=10, DWELL_CYCLES=3, INIT_FLOOR=0)
REQ-028 Reset then idle -> sensoresNeg=1110, andar=0, all flags 0.
REQ-029 motorSubindo held -> em_movimento 1 cycle after command; sensoresNeg=1111 for 10 cycles; then andar=1, sensoresNeg=1101, chegou one pulse; 3 dwell cycles; next floor travel starts; top at floor 3 with sobrecurso=1 and state PARADO.
REQ-030 Up 4 cycles, both motors 3 cycles, down held -> falha high 3 cycles, counter held, reversal mirror-loads 5, arrival after 6 down cycles at floor 0, sensoresNeg=1110.
REQ-031 At floor 0, motorDescendo pulse -> sobrecurso=1, andar=0, no motion; stays 1 until reset.
REQ-032 Reset asserted mid-TRANSITO between floors 2 and 3 -> next cycle andar=0, sensoresNeg=1110, em_movimento=0.
REQ-033 Command removed mid-transit for 20 cycles then restored -> total 10 counting cycles before arrival, sensoresNeg all ones throughout pause.

Source files
------------

// File: rtl/elevator_sim_pkg.sv
// Shared types and helpers for the elevator plant model: FSM states, travel
// direction and the active-low one-hot floor sensor encoding.
package elevator_sim_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    TRANSITO = 2'd1,
    CHEGADA  = 2'd2
  } estado_t;

  typedef enum logic {
    DIR_SOBE  = 1'b0,
    DIR_DESCE = 1'b1
  } direcao_t;

  localparam int MAX_FLOORS = 16;

  // Sensor word for a car parked at 'floor': that bit low, all others high.
  function automatic logic [MAX_FLOORS-1:0] sensor_neg(input logic [3:0] floor);
    return ~(16'd1 << floor);
  endfunction

endpackage

// File: rtl/elevator_plant_model_contador_viagem.sv
// Travel counter between two floors: clears, counts up, holds, or mirror-loads
// (TRAVEL_CYCLES-1-count) so a reversal covers the distance already travelled.
module contador_viagem
  import elevator_sim_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 2500
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic mirror,
  output logic no_fim
);

  localparam int CNT_W = $clog2(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TRAVEL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (mirror) begin
      count <= LAST - count;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign no_fim = (count == LAST);

endmodule

// File: rtl/elevator_plant_model.sv
// Cycle-level elevator shaft plant: turns motor commands into floor sensors,
// floor position and status flags, with every output registered.
module elevator_plant_model
  import elevator_sim_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 2500,
  parameter int DWELL_CYCLES  = 50,
  parameter int INIT_FLOOR    = 0,
  parameter int FLOOR_W       = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  motorSubindo,
  input  logic                  motorDescendo,
  output logic [NUM_FLOORS-1:0] sensoresNeg,
  output logic [FLOOR_W-1:0]    andar,
  output logic                  em_movimento,
  output logic                  chegou,
  output logic                  falha,
  output logic                  sobrecurso
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0]    DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] INIT       = FLOOR_W'(INIT_FLOOR);

  estado_t          estado;
  direcao_t         dir;
  logic             voltando;
  logic [DW_W-1:0]  dwell;
  logic [FLOOR_W-1:0] destino;

  logic cmd_up, cmd_down, cmd_fwd, cmd_rev;
  logic partida, bloqueio, no_fim;
  logic cnt_clr, cnt_inc, cnt_mirror;

  assign cmd_up   = motorSubindo & ~motorDescendo;
  assign cmd_down = motorDescendo & ~motorSubindo;
  assign cmd_fwd  = (dir == DIR_SOBE) ? cmd_up : cmd_down;
  assign cmd_rev  = (dir == DIR_SOBE) ? cmd_down : cmd_up;

  assign partida  = (cmd_up && andar != TOP_FLOOR) || (cmd_down && andar != '0);
  assign bloqueio = (cmd_up && andar == TOP_FLOOR) || (cmd_down && andar == '0);

  assign cnt_clr    = (estado == PARADO && partida) ||
                      (estado == TRANSITO && cmd_fwd && no_fim);
  assign cnt_inc    = (estado == TRANSITO) && cmd_fwd && !no_fim;
  assign cnt_mirror = (estado == TRANSITO) && cmd_rev;

  // After an odd number of reversals the car is heading back to the floor it left.
  always_comb begin
    destino = andar;
    if (!voltando) begin
      destino = (dir == DIR_SOBE) ? andar + FLOOR_W'(1) : andar - FLOOR_W'(1);
    end
  end

  contador_viagem #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .mirror(cnt_mirror),
    .no_fim(no_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= PARADO;
      andar        <= INIT;
      dir          <= DIR_SOBE;
      voltando     <= 1'b0;
      dwell        <= '0;
      sensoresNeg  <= NUM_FLOORS'(sensor_neg(4'(INIT)));
      em_movimento <= 1'b0;
      chegou       <= 1'b0;
      falha        <= 1'b0;
      sobrecurso   <= 1'b0;
    end else begin
      falha  <= motorSubindo & motorDescendo;
      chegou <= 1'b0;
      case (estado)
        PARADO: begin
          if (partida) begin
            estado       <= TRANSITO;
            dir          <= cmd_up ? DIR_SOBE : DIR_DESCE;
            voltando     <= 1'b0;
            sensoresNeg  <= '1;
            em_movimento <= 1'b1;
          end else if (bloqueio) begin
            sobrecurso <= 1'b1;
          end
        end
        TRANSITO: begin
          if (cmd_fwd && no_fim) begin
            estado       <= CHEGADA;
            andar        <= destino;
            sensoresNeg  <= NUM_FLOORS'(sensor_neg(4'(destino)));
            em_movimento <= 1'b0;
            chegou       <= 1'b1;
            dwell        <= '0;
          end else if (cmd_rev) begin
            dir      <= (dir == DIR_SOBE) ? DIR_DESCE : DIR_SOBE;
            voltando <= ~voltando;
          end
        end
        CHEGADA: begin
          if (dwell == DWELL_LAST) begin
            estado <= PARADO;
          end else begin
            dwell <= dwell + DW_W'(1);
          end
        end
        default: estado <= PARADO;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_plant_model.sv
// Scoreboard bench for elevator_plant_model (4 floors, 10 travel, 3 dwell):
// stimulus queues the hand-derived outputs for each edge, a monitor compares.
module tb_elevator_plant_model;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       motorSubindo = 1'b0;
  logic       motorDescendo = 1'b0;
  logic [3:0] sensoresNeg;
  logic [1:0] andar;
  logic       em_movimento, chegou, falha, sobrecurso;

  elevator_plant_model #(
    .NUM_FLOORS(4),
    .TRAVEL_CYCLES(10),
    .DWELL_CYCLES(3),
    .INIT_FLOOR(0)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .motorSubindo (motorSubindo),
    .motorDescendo(motorDescendo),
    .sensoresNeg  (sensoresNeg),
    .andar        (andar),
    .em_movimento (em_movimento),
    .chegou       (chegou),
    .falha        (falha),
    .sobrecurso   (sobrecurso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   exp_so = 1'b0;

  function automatic logic [3:0] sn(input int f);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << f);
  endfunction

  // Monitor: compare one queued expectation per cycle, away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = exp_q.pop_front();
      act = {sensoresNeg, andar, em_movimento, chegou, falha, sobrecurso};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got sens=%b andar=%0d mov=%b chegou=%b falha=%b sobre=%b, expected sens=%b andar=%0d mov=%b chegou=%b falha=%b sobre=%b",
                 e.nm, act[9:6], act[5:4], act[3], act[2], act[1], act[0],
                 e.v[9:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic cyc(input bit r, input bit up, input bit dn, input logic [3:0] s,
                     input int a, input bit mov, input bit ch, input bit fa,
                     input string nm);
    exp_t e;
    reset = r; motorSubindo = up; motorDescendo = dn;
    @(posedge clk);
    e.v  = {s, 2'(a), mov, ch, fa, exp_so};
    e.nm = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    exp_so = 1'b0;
    cyc(1, 0, 0, 4'b1110, 0, 0, 0, 0, "reset");
  endtask

  // One full floor-to-floor leg with the command held, including the dwell.
  task automatic leg(input int f, input int t, input bit up);
    cyc(0, up, !up, 4'b1111, f, 1, 0, 0, "leg_start");
    repeat (9) cyc(0, up, !up, 4'b1111, f, 1, 0, 0, "leg_transit");
    cyc(0, up, !up, sn(t), t, 0, 1, 0, "leg_arrive");
    repeat (3) cyc(0, up, !up, sn(t), t, 0, 0, 0, "leg_dwell");
  endtask

  initial begin
    @(negedge clk);
    // Reset and idle
    do_reset();
    cyc(0, 0, 0, 4'b1110, 0, 0, 0, 0, "idle");
    cyc(0, 0, 0, 4'b1110, 0, 0, 0, 0, "idle");

    // Up held all the way to the top, then overtravel at floor 3
    leg(0, 1, 1);
    leg(1, 2, 1);
    leg(2, 3, 1);
    exp_so = 1'b1;
    cyc(0, 1, 0, 4'b0111, 3, 0, 0, 0, "top_overtravel");
    cyc(0, 1, 0, 4'b0111, 3, 0, 0, 0, "top_stays");
    cyc(0, 0, 0, 4'b0111, 3, 0, 0, 0, "top_sticky");
    do_reset();

    // Up 4 counting cycles, both motors 3 cycles, reversal back to floor 0
    cyc(0, 1, 0, 4'b1111, 0, 1, 0, 0, "rev_start");
    repeat (4) cyc(0, 1, 0, 4'b1111, 0, 1, 0, 0, "rev_up");
    repeat (3) cyc(0, 1, 1, 4'b1111, 0, 1, 0, 1, "both_falha");
    repeat (5) cyc(0, 0, 1, 4'b1111, 0, 1, 0, 0, "rev_down");
    cyc(0, 0, 1, 4'b1110, 0, 0, 1, 0, "rev_arrive");
    repeat (3) cyc(0, 0, 0, 4'b1110, 0, 0, 0, 0, "rev_dwell");

    // Down at bottom floor
    exp_so = 1'b1;
    cyc(0, 0, 1, 4'b1110, 0, 0, 0, 0, "bottom_overtravel");
    cyc(0, 0, 0, 4'b1110, 0, 0, 0, 0, "bottom_sticky");
    cyc(0, 0, 0, 4'b1110, 0, 0, 0, 0, "bottom_sticky");
    do_reset();

    // Reset mid-transit between floors 2 and 3
    leg(0, 1, 1);
    leg(1, 2, 1);
    cyc(0, 1, 0, 4'b1111, 2, 1, 0, 0, "mid_start");
    repeat (4) cyc(0, 1, 0, 4'b1111, 2, 1, 0, 0, "mid_transit");
    do_reset();
    cyc(0, 0, 0, 4'b1110, 0, 0, 0, 0, "after_mid_reset");

    // Pause mid-transit: counter holds, sensors stay all ones
    cyc(0, 1, 0, 4'b1111, 0, 1, 0, 0, "pause_start");
    repeat (3) cyc(0, 1, 0, 4'b1111, 0, 1, 0, 0, "pause_pre");
    repeat (20) cyc(0, 0, 0, 4'b1111, 0, 1, 0, 0, "pause_hold");
    repeat (6) cyc(0, 1, 0, 4'b1111, 0, 1, 0, 0, "pause_post");
    cyc(0, 1, 0, 4'b1101, 1, 0, 1, 0, "pause_arrive");
    // Down during dwell is ignored, then starts travel from PARADO
    repeat (3) cyc(0, 0, 1, 4'b1101, 1, 0, 0, 0, "dwell_ignore");
    cyc(0, 0, 1, 4'b1111, 1, 1, 0, 0, "start_after_dwell");
    do_reset();

    begin
      int budget;
      budget = 5;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
